// File: rtl/wb_mem_arb3.sv
// Round-robin Wishbone B3 arbiter sharing one memory port between debug, dbus and ibus masters.
// A grant lasts for the owner's whole bus cycle; a watchdog aborts strobes the slave never terminates.
module wb_mem_arb3 #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [3*AW-1:0]       m_adr_i,
    input  logic [3*DW-1:0]       m_dat_i,
    input  logic [3*(DW/8)-1:0]   m_sel_i,
    input  logic [2:0]            m_we_i,
    input  logic [2:0]            m_cyc_i,
    input  logic [2:0]            m_stb_i,
    input  logic [8:0]            m_cti_i,
    input  logic [5:0]            m_bte_i,
    output logic [DW-1:0]         m_dat_o,
    output logic [2:0]            m_ack_o,
    output logic [2:0]            m_err_o,
    output logic [2:0]            m_rty_o,
    output logic [AW-1:0]         s_adr_o,
    output logic [DW-1:0]         s_dat_o,
    output logic [DW/8-1:0]       s_sel_o,
    output logic                  s_we_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic [2:0]            s_cti_o,
    output logic [1:0]            s_bte_o,
    input  logic [DW-1:0]         s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    output logic [2:0]            grant_o,
    output logic                  timeout_o
);
    localparam int SW = DW / 8;
    localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LAST = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ABORT = 2'd2} state_t;

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_owner, w_owner_nxt;
    logic [1:0]    r_last, w_last_nxt;
    logic [1:0]    w_pick, w_sel;
    logic [WW-1:0] r_wdog, w_wdog_nxt;
    logic          r_timeout, w_timeout_nxt;
    logic [2:0]    w_own_oh;
    logic          w_own_cyc, w_own_stb, w_term;

    // Rotation 0->1->2->0 starting just after the previous owner.
    always_comb begin
        case (r_last)
            2'd0:    w_pick = m_cyc_i[1] ? 2'd1 : (m_cyc_i[2] ? 2'd2 : 2'd0);
            2'd1:    w_pick = m_cyc_i[2] ? 2'd2 : (m_cyc_i[0] ? 2'd0 : 2'd1);
            default: w_pick = m_cyc_i[0] ? 2'd0 : (m_cyc_i[1] ? 2'd1 : 2'd2);
        endcase
    end

    assign w_sel     = (r_owner == 2'd3) ? 2'd0 : r_owner;
    assign w_own_cyc = m_cyc_i[w_sel];
    assign w_own_stb = m_stb_i[w_sel];
    assign w_own_oh  = 3'b001 << w_sel;
    assign w_term    = s_ack_i | s_err_i | s_rty_i;
    assign timeout_o = r_timeout;

    // Next-state logic: grant in IDLE, hold until the owner drops cyc, watchdog into ABORT.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_last_nxt    = r_last;
        w_wdog_nxt    = '0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (|m_cyc_i) begin
                    w_state_nxt = BUSY;
                    w_owner_nxt = w_pick;
                    w_last_nxt  = w_pick;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                end else if (w_term) begin
                    w_wdog_nxt = '0;
                end else if (w_own_stb) begin
                    if ((TIMEOUT != 0) && (r_wdog == WD_LAST)) begin
                        w_state_nxt   = ABORT;
                        w_timeout_nxt = 1'b1;
                    end else begin
                        w_wdog_nxt = r_wdog + 1'b1;
                    end
                end else begin
                    w_wdog_nxt = r_wdog;
                end
            end
            ABORT: begin
                if (!w_own_cyc) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = ABORT;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State registers with synchronous reset; last=2 lets master 0 win first.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_owner   <= 2'd0;
            r_last    <= 2'd2;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_owner   <= w_owner_nxt;
            r_last    <= w_last_nxt;
            r_wdog    <= w_wdog_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Slave-side mux and owner-only termination routing.
    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = 3'b000;
        s_bte_o = 2'b00;
        m_ack_o = 3'b000;
        m_err_o = 3'b000;
        m_rty_o = 3'b000;
        grant_o = 3'b000;
        m_dat_o = s_dat_i;
        case (r_state)
            BUSY: begin
                s_adr_o = m_adr_i[w_sel*AW +: AW];
                s_dat_o = m_dat_i[w_sel*DW +: DW];
                s_sel_o = m_sel_i[w_sel*SW +: SW];
                s_we_o  = m_we_i[w_sel];
                s_cyc_o = w_own_cyc;
                s_stb_o = w_own_stb;
                s_cti_o = m_cti_i[w_sel*3 +: 3];
                s_bte_o = m_bte_i[w_sel*2 +: 2];
                m_ack_o = {3{s_ack_i}} & w_own_oh;
                m_err_o = {3{s_err_i}} & w_own_oh;
                m_rty_o = {3{s_rty_i}} & w_own_oh;
                grant_o = w_own_oh;
            end
            ABORT: begin
                grant_o = w_own_oh;
                m_err_o = {3{w_own_stb}} & w_own_oh;
            end
            default: begin
                grant_o = 3'b000;
            end
        endcase
    end
endmodule

// File: tb/tb_wb_mem_arb3.sv
// Bench for wb_mem_arb3: directed sequences, a vector table and random traffic against a cycle model.
// Instance a has TIMEOUT=8, instance b has the watchdog disabled.
module tb_wb_mem_arb3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO_A = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [3*AW-1:0]   m_adr;
    logic [3*DW-1:0]   m_dat;
    logic [3*SW-1:0]   m_sel;
    logic [2:0]        m_we, m_cyc, m_stb;
    logic [8:0]        m_cti;
    logic [5:0]        m_bte;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack, s_err, s_rty;

    logic [DW-1:0] a_m_dat, b_m_dat;
    logic [2:0]    a_m_ack, a_m_err, a_m_rty, b_m_ack, b_m_err, b_m_rty;
    logic [AW-1:0] a_s_adr, b_s_adr;
    logic [DW-1:0] a_s_dat, b_s_dat;
    logic [SW-1:0] a_s_sel, b_s_sel;
    logic          a_s_we, a_s_cyc, a_s_stb, b_s_we, b_s_cyc, b_s_stb;
    logic [2:0]    a_s_cti, b_s_cti, a_grant, b_grant;
    logic [1:0]    a_s_bte, b_s_bte;
    logic          a_to, b_to;

    wb_mem_arb3 #(.AW(AW), .DW(DW), .TIMEOUT(TO_A)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(a_m_dat), .m_ack_o(a_m_ack), .m_err_o(a_m_err), .m_rty_o(a_m_rty),
        .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_sel_o(a_s_sel), .s_we_o(a_s_we),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_cti_o(a_s_cti), .s_bte_o(a_s_bte),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(a_grant), .timeout_o(a_to)
    );

    wb_mem_arb3 #(.AW(AW), .DW(DW), .TIMEOUT(0)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_cti_i(m_cti), .m_bte_i(m_bte),
        .m_dat_o(b_m_dat), .m_ack_o(b_m_ack), .m_err_o(b_m_err), .m_rty_o(b_m_rty),
        .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_sel_o(b_s_sel), .s_we_o(b_s_we),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_cti_o(b_s_cti), .s_bte_o(b_s_bte),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
        .grant_o(b_grant), .timeout_o(b_to)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: mode 0 idle, 1 owned, 2 aborted; stall counts unanswered strobes.
    int md_mode = 0;
    int md_own = 0;
    int md_last = 2;
    int md_stall = 0;
    bit md_first = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_check();
        bit busy, ab;
        logic [2:0] oh;
        busy = (md_mode == 1);
        ab   = (md_mode == 2);
        oh   = (busy || ab) ? 3'(1 << md_own) : 3'b000;
        check("grant",   a_grant, oh);
        check("s_cyc",   a_s_cyc, busy ? m_cyc[md_own] : 1'b0);
        check("s_stb",   a_s_stb, busy ? m_stb[md_own] : 1'b0);
        check("s_we",    a_s_we,  busy ? m_we[md_own]  : 1'b0);
        check("s_adr",   a_s_adr, busy ? m_adr[md_own*AW +: AW] : 32'h0);
        check("s_dat",   a_s_dat, busy ? m_dat[md_own*DW +: DW] : 32'h0);
        check("s_sel",   a_s_sel, busy ? m_sel[md_own*SW +: SW] : 4'h0);
        check("s_cti",   a_s_cti, busy ? m_cti[md_own*3 +: 3] : 3'b000);
        check("s_bte",   a_s_bte, busy ? m_bte[md_own*2 +: 2] : 2'b00);
        check("m_ack",   a_m_ack, (busy && s_ack) ? oh : 3'b000);
        check("m_rty",   a_m_rty, (busy && s_rty) ? oh : 3'b000);
        check("m_err",   a_m_err, busy ? (s_err ? oh : 3'b000) : ((ab && m_stb[md_own]) ? oh : 3'b000));
        check("m_dat",   a_m_dat, s_dat_i);
        check("timeout", a_to,    md_first);
    endtask

    task automatic model_advance();
        bit found;
        if (rst) begin
            md_mode = 0; md_last = 2; md_stall = 0; md_first = 1'b0;
        end else if (md_mode == 0) begin
            md_first = 1'b0;
            found = 1'b0;
            for (int k = 1; k <= 3; k++) begin
                if (!found && m_cyc[(md_last + k) % 3]) begin
                    md_own = (md_last + k) % 3;
                    found = 1'b1;
                end
            end
            if (found) begin
                md_last = md_own; md_mode = 1; md_stall = 0;
            end
        end else if (md_mode == 1) begin
            md_first = 1'b0;
            if (!m_cyc[md_own]) begin
                md_mode = 0; md_stall = 0;
            end else if (s_ack || s_err || s_rty) begin
                md_stall = 0;
            end else if (m_stb[md_own]) begin
                if (md_stall + 1 == TO_A) begin
                    md_mode = 2; md_first = 1'b1; md_stall = 0;
                end else begin
                    md_stall++;
                end
            end
        end else begin
            md_first = 1'b0;
            if (!m_cyc[md_own]) md_mode = 0;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc1();
        settle();
        tick();
    endtask

    task automatic set_m(input int i, input bit c, input bit s, input bit we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        m_cyc[i] = c;
        m_stb[i] = s;
        m_we[i]  = we;
        m_adr[i*AW +: AW] = adr;
        m_dat[i*DW +: DW] = dat;
        m_sel[i*SW +: SW] = 4'hF;
        m_cti[i*3 +: 3]   = cti;
        m_bte[i*2 +: 2]   = 2'b00;
    endtask

    task automatic do_reset();
        m_cyc = 3'b000; m_stb = 3'b000;
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        rst = 1'b1;
        cyc1();
        cyc1();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0] cyc;
        logic       ack;
        logic [2:0] e_grant;
        logic [2:0] e_ack;
        logic       e_scyc;
    } rr_vec_t;

    rr_vec_t rr[13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit err_seen, to_seen, grant_bad;
        int r;

        rr[0]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
        rr[1]  = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b1};
        rr[2]  = '{3'b110, 1'b0, 3'b001, 3'b000, 1'b0};
        rr[3]  = '{3'b110, 1'b1, 3'b000, 3'b000, 1'b0};
        rr[4]  = '{3'b110, 1'b1, 3'b010, 3'b010, 1'b1};
        rr[5]  = '{3'b100, 1'b0, 3'b010, 3'b000, 1'b0};
        rr[6]  = '{3'b100, 1'b0, 3'b000, 3'b000, 1'b0};
        rr[7]  = '{3'b100, 1'b1, 3'b100, 3'b100, 1'b1};
        rr[8]  = '{3'b000, 1'b0, 3'b100, 3'b000, 1'b0};
        rr[9]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0};
        rr[10] = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b1};
        rr[11] = '{3'b000, 1'b0, 3'b001, 3'b000, 1'b0};
        rr[12] = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0};

        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 3'b000; m_cyc = 3'b000; m_stb = 3'b000;
        m_cti = 9'h0; m_bte = 6'h0; s_dat_i = 32'h0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc1();
        cyc1();
        rst = 1'b0;

        // Single read by master 1, slave answers two cycles after the strobe.
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 3'b000);
        settle(); check("rd_idle_grant", a_grant, 3'b000); tick();
        settle(); check("rd_s_adr", a_s_adr, 32'h100); check("rd_s_stb", a_s_stb, 1'b1); tick();
        cyc1();
        s_ack = 1'b1; s_dat_i = 32'hDEADBEEF;
        settle(); check("rd_ack", a_m_ack, 3'b010); check("rd_dat", a_m_dat, 32'hDEADBEEF); tick();
        s_ack = 1'b0; set_m(1, 1'b0, 1'b0, 1'b0, 32'h100, 32'h0, 3'b000);
        settle(); check("rd_ack_once", a_m_ack, 3'b000); tick();
        settle(); check("rd_release", a_s_cyc, 1'b0); tick();

        // Round-robin vector table.
        do_reset();
        for (int i = 0; i < 3; i++) set_m(i, 1'b0, 1'b0, 1'b0, 32'h1000 * (i + 1), 32'h0, 3'b000);
        for (int v = 0; v < 13; v++) begin
            m_cyc = rr[v].cyc; m_stb = rr[v].cyc; s_ack = rr[v].ack;
            settle();
            check($sformatf("rr%0d_grant", v), a_grant, rr[v].e_grant);
            check($sformatf("rr%0d_ack", v),   a_m_ack, rr[v].e_ack);
            check($sformatf("rr%0d_scyc", v),  a_s_cyc, rr[v].e_scyc);
            tick();
        end
        s_ack = 1'b0;

        // Burst by master 2 holds the grant while master 0 waits.
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 3'b000);
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, 3'b010);
        cyc1();
        for (int k = 0; k < 4; k++) begin
            set_m(2, 1'b1, 1'b1, 1'b0, 32'h200 + 32'(4 * k), 32'h0, (k == 3) ? 3'b111 : 3'b010);
            s_ack = 1'b1;
            settle();
            check($sformatf("bu%0d_adr", k), a_s_adr, 32'h200 + 32'(4 * k));
            check($sformatf("bu%0d_grant", k), a_grant, 3'b100);
            check($sformatf("bu%0d_ack", k), a_m_ack, 3'b100);
            tick();
        end
        s_ack = 1'b0; set_m(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        settle(); check("bu_drop_grant", a_grant, 3'b100); tick();
        settle(); check("bu_bubble", a_grant, 3'b000); tick();
        s_ack = 1'b1;
        settle(); check("bu_m0_grant", a_grant, 3'b001); check("bu_m0_adr", a_s_adr, 32'h50); tick();
        s_ack = 1'b0; set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        cyc1();
        cyc1();

        // Watchdog: master 1 write, slave silent.
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h12345678, 3'b000);
        cyc1();
        settle(); check("wd_stb", a_s_stb, 1'b1); check("wd_s_dat", a_s_dat, 32'h12345678); tick();
        for (int k = 1; k < TO_A; k++) begin
            settle(); check($sformatf("wd_wait%0d_err", k), a_m_err, 3'b000); tick();
        end
        s_ack = 1'b1;
        settle();
        check("wd_err", a_m_err, 3'b010); check("wd_pulse", a_to, 1'b1);
        check("wd_scyc", a_s_cyc, 1'b0); check("wd_late_ack", a_m_ack, 3'b000);
        check("wd_off_err", b_m_err, 3'b000); check("wd_off_to", b_to, 1'b0);
        tick();
        s_ack = 1'b0;
        settle(); check("wd_err2", a_m_err, 3'b010); check("wd_pulse_once", a_to, 1'b0); tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        cyc1();
        settle(); check("wd_idle", a_grant, 3'b000); tick();

        // Reset during a master 0 burst, then all three request.
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 3'b010);
        cyc1();
        s_ack = 1'b1;
        settle(); check("rs_grant", a_grant, 3'b001); tick();
        rst = 1'b1; s_ack = 1'b0;
        cyc1();
        rst = 1'b0;
        m_cyc = 3'b111; m_stb = 3'b111;
        settle(); check("rs_scyc", a_s_cyc, 1'b0); check("rs_grant0", a_grant, 3'b000); tick();
        settle(); check("rs_first", a_grant, 3'b001); tick();
        m_cyc = 3'b000; m_stb = 3'b000;
        cyc1();
        cyc1();

        // Watchdog disabled: long stall keeps the grant and never errors.
        do_reset();
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 3'b000);
        cyc1();
        err_seen = 1'b0; to_seen = 1'b0; grant_bad = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (b_m_err != 3'b000) err_seen = 1'b1;
            if (b_to) to_seen = 1'b1;
            if (b_grant != 3'b100) grant_bad = 1'b1;
            tick();
        end
        check("off_err", err_seen, 1'b0);
        check("off_to", to_seen, 1'b0);
        check("off_grant", grant_bad, 1'b0);
        @(negedge clk); check("off_scyc", b_s_cyc, 1'b1); tick();
        m_cyc = 3'b000; m_stb = 3'b000;
        cyc1();
        cyc1();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 9) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i] = m_cyc[i] & ($urandom_range(0, 9) < 7);
                m_we[i] = 1'($urandom);
                m_adr[i*AW +: AW] = 32'($urandom);
                m_dat[i*DW +: DW] = 32'($urandom);
                m_sel[i*SW +: SW] = 4'($urandom);
                m_cti[i*3 +: 3] = 3'($urandom);
                m_bte[i*2 +: 2] = 2'($urandom);
            end
            r = int'($urandom_range(0, 99));
            s_ack = (r < 20);
            s_err = (r >= 20) && (r < 25);
            s_rty = (r >= 25) && (r < 30);
            s_dat_i = 32'($urandom);
            cyc1();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
